// File: rtl/spi_slave_serdes.sv
// SPI mode-3 slave word serializer/deserializer, fully oversampled in the system clock domain.
// SCLK/CSB/SDI pass through equal-depth synchronizers so sampled data lines up with detected edges.
module spi_slave_serdes #(
  parameter int cShiftRegWidth = 16,
  parameter int cSyncStages    = 2
) (
  input  logic                      sys_clock_i,
  input  logic                      sys_reset_i,
  input  logic                      spi_clk_i,
  input  logic                      spi_csb_i,
  input  logic                      spi_sdi_i,
  output logic                      spi_sdo_o,
  output logic                      spi_sdo_oe_o,
  input  logic [cShiftRegWidth-1:0] tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [cShiftRegWidth-1:0] rx_data_o,
  output logic                      rx_valid_o,
  output logic                      busy_o,
  output logic                      underrun_o,
  output logic                      abort_o,
  input  logic                      clear_flags_i
);
  localparam int W  = cShiftRegWidth;
  localparam int NW = $clog2(W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [cSyncStages-1:0] sclk_sync_q, sclk_sync_d;
  logic [cSyncStages-1:0] csb_sync_q, csb_sync_d;
  logic [cSyncStages-1:0] sdi_sync_q, sdi_sync_d;
  logic [cSyncStages-1:0] warm_q, warm_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [1:0]             state_q, state_d;
  logic [NW-1:0]          n_q, n_d;
  logic [W-2:0]           tx_sr_q, tx_sr_d;
  logic [W-2:0]           rx_sr_q, rx_sr_d;
  logic                   sdo_q, sdo_d;
  logic                   pend_q, pend_d;
  logic [W-1:0]           hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [W-1:0]           rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   abort_q, abort_d;
  logic                   armed_q, armed_d;

  logic         sclk_s, csb_s, sdi_s, warm, rise, fall;
  logic         consume, underrun_set;
  logic [W-1:0] rx_word;

  assign sclk_s = sclk_sync_q[cSyncStages-1];
  assign csb_s  = csb_sync_q[cSyncStages-1];
  assign sdi_s  = sdi_sync_q[cSyncStages-1];
  assign warm   = warm_q[cSyncStages-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[cSyncStages-2:0], spi_clk_i};
    csb_sync_d   = {csb_sync_q[cSyncStages-2:0], spi_csb_i};
    sdi_sync_d   = {sdi_sync_q[cSyncStages-2:0], spi_sdi_i};
    warm_d       = {warm_q[cSyncStages-2:0], 1'b1};
    sclk_prev_d  = sclk_s;
    state_d      = state_q;
    n_d          = n_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    sdo_d        = sdo_q;
    pend_d       = pend_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    abort_d      = 1'b0;
    armed_d      = armed_q;
    consume      = 1'b0;
    underrun_set = 1'b0;
    rx_word      = {rx_sr_q, sdi_s};

    case (state_q)
      ST_IDLE: begin
        sdo_d  = 1'b1;
        n_d    = '0;
        pend_d = 1'b0;
        // A frame already in progress when reset lifts is never joined mid-way.
        if (warm) begin
          if (csb_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = ST_SHIFT;
            consume = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        sdo_d = 1'b1;
        if (csb_s) state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (csb_s) begin
          state_d = ST_IDLE;
          sdo_d   = 1'b1;
          n_d     = '0;
          pend_d  = 1'b0;
          abort_d = (n_q != '0);
        end else if (rise) begin
          rx_sr_d = rx_word[W-2:0];
          if (n_q == NW'(W - 1)) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            n_d        = '0;
            // Empty buffer at a word boundary: defer the underrun decision to the
            // next word's first SCLK fall, so a clean end of frame is not flagged.
            if (hold_full_q) begin
              consume = 1'b1;
            end else begin
              pend_d  = 1'b1;
              tx_sr_d = '1;
              sdo_d   = 1'b1;
            end
          end else begin
            n_d = n_q + NW'(1);
          end
        end else if (fall) begin
          if (n_q != '0) begin
            sdo_d   = tx_sr_q[W-2];
            tx_sr_d = (W-1)'({tx_sr_q, 1'b1});
          end else if (pend_q) begin
            pend_d  = 1'b0;
            consume = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (consume) begin
      if (hold_full_q) begin
        sdo_d       = hold_q[W-1];
        tx_sr_d     = hold_q[W-2:0];
        hold_full_d = 1'b0;
      end else begin
        sdo_d        = 1'b1;
        tx_sr_d      = '1;
        underrun_set = 1'b1;
      end
    end

    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    underrun_d = underrun_set | (underrun_q & ~clear_flags_i);
  end

  always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      sclk_sync_q <= '1;
      csb_sync_q  <= '1;
      sdi_sync_q  <= '1;
      warm_q      <= '0;
      sclk_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      n_q         <= '0;
      tx_sr_q     <= '1;
      rx_sr_q     <= '0;
      sdo_q       <= 1'b1;
      pend_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csb_sync_q  <= csb_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      warm_q      <= warm_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      n_q         <= n_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      sdo_q       <= sdo_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
      armed_q     <= armed_d;
    end
  end

  assign spi_sdo_o    = sdo_q;
  assign spi_sdo_oe_o = (state_q != ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign tx_ready_o   = ~hold_full_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign underrun_o   = underrun_q;
  assign abort_o      = abort_q;
endmodule

// File: tb/tb_spi_slave_serdes.sv
// Bench for spi_slave_serdes: a mode-3 SPI master model drives frames; received words are
// checked by a scoreboard monitor, MISO words and status flags are checked by the stimulus.
module tb_spi_slave_serdes;
  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk, spi_csb, spi_sdi;
  logic        spi_sdo, spi_sdo_oe;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, busy, underrun, abort_p, clear_flags;

  int errors = 0;
  int checks = 0;
  int rx_seen = 0;
  int abort_seen = 0;
  logic [15:0] rx_exp_q[$];

  spi_slave_serdes #(.cShiftRegWidth(16), .cSyncStages(2)) dut (
    .sys_clock_i  (clk),
    .sys_reset_i  (rst),
    .spi_clk_i    (spi_clk),
    .spi_csb_i    (spi_csb),
    .spi_sdi_i    (spi_sdi),
    .spi_sdo_o    (spi_sdo),
    .spi_sdo_oe_o (spi_sdo_oe),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .busy_o       (busy),
    .underrun_o   (underrun),
    .abort_o      (abort_p),
    .clear_flags_i(clear_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_seen++;
      if (rx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected no word", rx_data);
      end else begin
        chk("rx_data", {16'h0, rx_data}, {16'h0, rx_exp_q.pop_front()});
      end
    end
    if (abort_p === 1'b1) abort_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_load(input logic [15:0] d);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 50) begin
      cyc(1);
      t++;
    end
    if (tx_ready !== 1'b1) chk("tx_ready_wait", 32'(tx_ready), 32'h1);
    tx_data  = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    cyc(1);
  endtask

  // Mode 3: drive MOSI on SCLK fall, sample MISO on SCLK rise.
  task automatic spi_xfer(input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
    miso = 16'h0;
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0;
      spi_sdi = mosi[15-i];
      cyc(4);
      spi_clk = 1'b1;
      miso = {miso[14:0], spi_sdo};
      cyc(4);
    end
  endtask

  task automatic csb_low();
    spi_csb = 1'b0;
    cyc(6);
  endtask

  task automatic csb_high();
    cyc(4);
    spi_csb = 1'b1;
    spi_sdi = 1'b1;
    cyc(6);
  endtask

  initial begin
    logic [15:0] m, a, b;
    int ab0, rx0;
    rst = 1'b1; spi_clk = 1'b1; spi_csb = 1'b1; spi_sdi = 1'b1;
    tx_data = 16'h0; tx_valid = 1'b0; clear_flags = 1'b0;
    cyc(3);
    chk("rst_sdo", 32'(spi_sdo), 32'h1);
    chk("rst_oe", 32'(spi_sdo_oe), 32'h0);
    chk("rst_ready", 32'(tx_ready), 32'h1);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    rst = 1'b0;
    cyc(5);

    // Single word frame
    tx_load(16'hA55A);
    chk("ready_full", 32'(tx_ready), 32'h0);
    rx_exp_q.push_back(16'h1234);
    csb_low();
    chk("busy_frame", 32'(busy), 32'h1);
    chk("oe_frame", 32'(spi_sdo_oe), 32'h1);
    chk("ready_after_load", 32'(tx_ready), 32'h1);
    spi_xfer(16'h1234, 16, m);
    chk("miso_a55a", 32'(m), 32'hA55A);
    csb_high();
    chk("oe_idle", 32'(spi_sdo_oe), 32'h0);
    chk("sdo_idle", 32'(spi_sdo), 32'h1);
    chk("rx_count1", rx_seen, 1);
    chk("rx_data1", 32'(rx_data), 32'h1234);

    // Two words in one frame, buffer refilled mid-first-word
    tx_load(16'hA55A);
    rx_exp_q.push_back(16'hCAFE);
    rx_exp_q.push_back(16'h0F0F);
    csb_low();
    spi_xfer(16'hCAFE, 8, a);
    tx_load(16'h00FF);
    spi_xfer(16'hFE00, 8, b);
    chk("miso_word1", 32'({a[7:0], b[7:0]}), 32'hA55A);
    spi_xfer(16'h0F0F, 16, m);
    chk("miso_word2", 32'(m), 32'h00FF);
    csb_high();
    chk("rx_count2", rx_seen, 3);
    chk("underrun_b2b", 32'(underrun), 32'h0);

    // Empty buffer: all ones, sticky underrun, clear, set-wins
    rx_exp_q.push_back(16'h5A5A);
    csb_low();
    spi_xfer(16'h5A5A, 16, m);
    chk("miso_ffff", 32'(m), 32'hFFFF);
    csb_high();
    chk("underrun_set", 32'(underrun), 32'h1);
    cyc(3);
    chk("underrun_sticky", 32'(underrun), 32'h1);
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    chk("underrun_clear", 32'(underrun), 32'h0);
    rx_exp_q.push_back(16'h0001);
    spi_csb = 1'b0;
    cyc(2);
    clear_flags = 1'b1;   // coincides with the load cycle of the empty buffer
    cyc(1);
    clear_flags = 1'b0;
    chk("underrun_set_wins", 32'(underrun), 32'h1);
    cyc(3);
    spi_xfer(16'h0001, 16, m);
    csb_high();
    chk("underrun_hold", 32'(underrun), 32'h1);
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    chk("underrun_clear2", 32'(underrun), 32'h0);

    // Abort after 7 bits, then a good frame
    tx_load(16'h3C3C);
    ab0 = abort_seen;
    rx0 = rx_seen;
    csb_low();
    spi_xfer(16'hFFFF, 7, m);
    chk("miso_partial", 32'(m[6:0]), 32'h1E);
    csb_high();
    chk("abort_pulse", abort_seen - ab0, 1);
    chk("abort_no_rx", rx_seen - rx0, 0);
    chk("abort_rx_data", 32'(rx_data), 32'h0001);
    chk("abort_busy", 32'(busy), 32'h0);
    tx_load(16'h1357);
    rx_exp_q.push_back(16'h2468);
    csb_low();
    spi_xfer(16'h2468, 16, m);
    chk("miso_after_abort", 32'(m), 32'h1357);
    csb_high();

    // Reset mid-word, release with CSB low
    tx_load(16'hBEEF);
    csb_low();
    spi_xfer(16'hFFFF, 5, m);
    rst = 1'b1;
    cyc(2);
    chk("mid_rst_sdo", 32'(spi_sdo), 32'h1);
    chk("mid_rst_oe", 32'(spi_sdo_oe), 32'h0);
    chk("mid_rst_ready", 32'(tx_ready), 32'h1);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_abort", 32'(abort_p), 32'h0);
    rst = 1'b0;
    cyc(6);
    chk("wait_busy", 32'(busy), 32'h1);
    rx0 = rx_seen;
    ab0 = abort_seen;
    spi_xfer(16'hA5A5, 16, m);
    csb_high();
    chk("wait_no_rx", rx_seen - rx0, 0);
    chk("wait_no_abort", abort_seen - ab0, 0);
    chk("wait_idle", 32'(busy), 32'h0);
    tx_load(16'h6789);
    rx_exp_q.push_back(16'hABCD);
    csb_low();
    spi_xfer(16'hABCD, 16, m);
    chk("miso_after_rst", 32'(m), 32'h6789);
    csb_high();
    chk("rx_data_after_rst", 32'(rx_data), 32'hABCD);
    chk("rx_count_total", rx_seen, 7);
    chk("scoreboard_empty", rx_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_serdes.md
SPI_SLAVE_SERDES -- requirements
Module: spi_slave_serdes

Interface
REQ-001 SHALL have parameter cShiftRegWidth, default 16: word length in bits (≥2).
REQ-002 SHALL have parameter cSyncStages, default 2: flip-flop stages in each SPI input synchronizer (≥2).
REQ-003 SHALL have port sys_clock_i  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_reset_i  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port spi_clk_i  input  1: SCLK from the master (CPOL=1, idle high).
REQ-006 SHALL have port spi_csb_i  input  1: active-low chip select.
REQ-007 SHALL have port spi_sdi_i  input  1: MOSI serial data, MSB first.
REQ-008 SHALL have port spi_sdo_o  output  1: MISO serial data, MSB first.
REQ-009 SHALL have port spi_sdo_oe_o  output  1: MISO output enable, high while selected.
REQ-010 SHALL have port tx_data_i  input  cShiftRegWidth: next word to transmit.
REQ-011 SHALL have port tx_valid_i  input  1: tx_data_i valid.
REQ-012 SHALL have port tx_ready_o  output  1: holding buffer empty; transfer occurs when tx_valid_i & tx_ready_o.
REQ-013 SHALL have port rx_data_o  output  cShiftRegWidth: last complete received word.
REQ-014 SHALL have port rx_valid_o  output  1: one-cycle pulse, rx_data_o updated.
REQ-015 SHALL have port busy_o  output  1: frame active (synchronized CSB low).
REQ-016 SHALL have port underrun_o  output  1: sticky; a word started with the holding buffer empty.
REQ-017 SHALL have port abort_o  output  1: one-cycle pulse; CSB deasserted mid-word.
REQ-018 SHALL have port clear_flags_i  input  1: synchronous clear of underrun_o.

Function
REQ-019 SHALL synchronize spi_clk_i, spi_csb_i, spi_sdi_i through cSyncStages flops each, so sampled SDI stays aligned with detected SCLK edges.
REQ-020 SHALL support sys_clock_i ≥ 8x SCLK frequency; slower ratios are out of scope.
REQ-021 SHALL use an FSM: IDLE (CSB high), SHIFT (CSB low, armed), WAIT_DESELECT (CSB low but not armed).
REQ-022 IDLE -> SHIFT on synchronized CSB fall: bit counter n=0, shift register loaded from the holding buffer, sdo = loaded MSB.
REQ-023 SHALL sample SDI into the receive shift register LSB on each detected SCLK rising edge and increment n.
REQ-024 SHALL update sdo to tx bit [W-1-n] on each detected SCLK falling edge with n>0; first falling edge (n=0) keeps the MSB.
REQ-025 On the rising edge that makes n=W: rx_data_o <= received word, rx_valid_o pulses the next cycle, n wraps to 0, next word loads from the holding buffer (multi-word frames).
REQ-026 If the holding buffer is empty at a word load: SHALL transmit all ones and set underrun_o.
REQ-027 tx_ready_o SHALL derive from registered buffer state only; a consume and an accept in the same cycle are impossible while full.
REQ-028 underrun_o set and clear_flags_i in the same cycle: set wins.
REQ-029 CSB rise in SHIFT with n≠0: SHALL pulse abort_o, discard the partial word, omit rx_valid_o, return to IDLE. Transmit word is consumed, not restored.
REQ-030 CSB rise with n=0: SHALL return to IDLE silently.
REQ-031 CSB high or IDLE: spi_sdo_o=1, spi_sdo_oe_o=0; SCLK edges ignored.
REQ-032 busy_o SHALL equal (state != IDLE).

Reset
REQ-033 During reset: spi_sdo_o=1, spi_sdo_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, underrun_o=0, abort_o=0, holding buffer empty, n=0, synchronizers =1 (CSB/SCLK idle).
REQ-034 Reset release with synchronized CSB low: SHALL enter WAIT_DESELECT and ignore SCLK until CSB high, then IDLE.

Verification
REQ-035 Load 0xA55A, frame with master sending 0x1234 in mode 3, 16 clocks -> MISO 0xA55A MSB first, rx_data_o=0x1234, one rx_valid_o pulse, tx_ready_o high after load.
REQ-036 Two back-to-back words in one CSB frame, buffer refilled with 0x00FF mid-first-word -> MISO 0xA55A then 0x00FF, two rx_valid_o pulses, underrun_o=0.
REQ-037 Frame with buffer empty -> MISO 0xFFFF, underrun_o=1 until clear_flags_i; clear and new underrun same cycle -> stays 1.
REQ-038 CSB deasserted after 7 bits -> abort_o one pulse, no rx_valid_o, rx_data_o unchanged, next full frame correct.
REQ-039 Assert sys_reset_i mid-word, release with CSB low -> no rx_valid_o until CSB high then a fresh full frame; outputs at reset values during reset.
